// File: rtl/timer_bank.sv
// timer_bank: CHANNELS independent WIDTH-bit timers with sticky irqs.
// Define TIMER_BANK_SYNC_EN to pass each tick through a 2-flop synchronizer.
module timer_bank #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] tick,
    input  logic                we,
    input  logic [2:0]          ch,
    input  logic [1:0]          reg_sel,
    input  logic [WIDTH-1:0]    wdata,
    output logic [WIDTH-1:0]    rdata,
    output logic [CHANNELS-1:0] chan_out,
    output logic [CHANNELS-1:0] irq,
    output logic                irq_any
);

    localparam logic [3:0]       NCH = 4'(CHANNELS);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic                ch_ok;
    logic [CHANNELS-1:0] tick_s;
    logic [CHANNELS-1:0] tick_q;
    logic [CHANNELS-1:0] pulse;

    logic [CHANNELS-1:0][WIDTH-1:0] count_q, count_d;
    logic [CHANNELS-1:0][WIDTH-1:0] reload_q, reload_d;
    logic [CHANNELS-1:0][1:0]       mode_q, mode_d;
    logic [CHANNELS-1:0]            en_q, en_d;
    logic [CHANNELS-1:0]            out_q, out_d;
    logic [CHANNELS-1:0]            irq_q, irq_d;
    logic [CHANNELS-1:0]            irq_set;
    logic [CHANNELS-1:0]            irq_clr;

    assign ch_ok = {1'b0, ch} < NCH;

`ifdef TIMER_BANK_SYNC_EN
    logic [CHANNELS-1:0] sync1_q, sync2_q;

    // two-flop synchronizer, idles high so a held-high tick never counts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= tick;
            sync2_q <= sync1_q;
        end
    end

    assign tick_s = sync2_q;
`else
    assign tick_s = tick;
`endif

    // previous tick level for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tick_q <= '1;
        else        tick_q <= tick_s;
    end

    assign pulse = tick_s & ~tick_q;

    // next-state: register writes take priority over a same-cycle pulse
    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        en_d     = en_q;
        out_d    = out_q;
        irq_set  = '0;
        irq_clr  = (we && reg_sel == 2'd2) ? wdata[CHANNELS-1:0] : '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (mode_q[i] == 2'd1) out_d[i] = 1'b0;
            if (we && ch_ok && ch == 3'(i) &&
                (reg_sel == 2'd0 || reg_sel == 2'd3)) begin
                count_d[i]  = wdata;
                reload_d[i] = wdata;
            end else if (we && ch_ok && ch == 3'(i) && reg_sel == 2'd1) begin
                mode_d[i] = wdata[1:0];
                en_d[i]   = wdata[2];
                out_d[i]  = 1'b0;
            end else if (pulse[i] && en_q[i]) begin
                unique case (mode_q[i])
                    2'd0: begin
                        if (count_q[i] > ONE) begin
                            count_d[i] = count_q[i] - ONE;
                        end else if (count_q[i] == ONE) begin
                            count_d[i] = '0;
                            out_d[i]   = 1'b1;
                            irq_set[i] = 1'b1;
                            en_d[i]    = 1'b0;
                        end
                    end
                    2'd1, 2'd2: begin
                        if (count_q[i] > ONE) begin
                            count_d[i] = count_q[i] - ONE;
                        end else if (reload_q[i] != '0) begin
                            count_d[i] = reload_q[i];
                            if (mode_q[i] == 2'd1) begin
                                out_d[i]   = 1'b1;
                                irq_set[i] = 1'b1;
                            end else begin
                                out_d[i]   = ~out_q[i];
                                irq_set[i] = ~out_q[i];
                            end
                        end else begin
                            count_d[i] = '0;
                        end
                    end
                    2'd3: begin
                        count_d[i] = count_q[i] + ONE;
                        irq_set[i] = &count_q[i];
                        out_d[i]   = count_d[i][WIDTH-1];
                    end
                endcase
            end
        end
        irq_d = (irq_q & ~irq_clr) | irq_set;
    end

    // channel state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= '0;
            en_q     <= '0;
            out_q    <= '0;
            irq_q    <= '0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            en_q     <= en_d;
            out_q    <= out_d;
            irq_q    <= irq_d;
        end
    end

    // register read mux, irq vector visible from any ch
    always_comb begin
        rdata = '0;
        if (reg_sel == 2'd2) begin
            rdata[CHANNELS-1:0] = irq_q;
        end else if (ch_ok) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (ch == 3'(i)) begin
                    case (reg_sel)
                        2'd0:    rdata = count_q[i];
                        2'd1:    rdata[4:0] = {irq_q[i], out_q[i], en_q[i], mode_q[i]};
                        default: rdata = reload_q[i];
                    endcase
                end
            end
        end
    end

    assign chan_out = out_q;
    assign irq      = irq_q;
    assign irq_any  = |irq_q;

endmodule

// File: doc/timer_bank.md
# timer_bank

Parametrised multi-channel timer/counter peripheral, the successor to the fixed three-channel counter on the MIO bus. It provides CHANNELS independent WIDTH-bit channels, each running in one of four modes: one-shot, periodic, square wave or free-running up-count. Each channel is clocked by rising edges of its own slow tick input, normally a clkdiv bit. Channels set sticky interrupt flags; the CPU reads and writes the block through a small register window decoded by the bus.

## Interface
Parameters:
- CHANNELS, 3, number of channels (1..8)
- WIDTH, 32, counter/reload width in bits (8..32)

Ports:
- clk  in  1  system clock (clk_IO domain)
- rst_n  in  1  asynchronous, active-low reset
- tick  in  CHANNELS  per-channel count source; only its rising edges count
- we  in  1  register write strobe, one cycle
- ch  in  3  channel select
- reg_sel  in  2  register select: 0 count, 1 control, 2 irq, 3 reload
- wdata  in  WIDTH  write data
- rdata  out  WIDTH  combinational read data for {ch, reg_sel}
- chan_out  out  CHANNELS  registered per-channel output bit
- irq  out  CHANNELS  sticky per-channel interrupt flags
- irq_any  out  1  OR of irq

## Operation
- Per-channel state: count, reload, mode[1:0], enable, out, irq.
- Edge detect: pulse[i] = tick[i] & ~tick_q[i], where tick_q is tick registered each clk. tick_q resets to all-ones, so a tick already high at reset release is not counted.
- Writes, when we=1 and ch<CHANNELS:
  - reg_sel 0 or 3: reload<=wdata[WIDTH-1:0] and count<=wdata.
  - reg_sel 1: mode<=wdata[1:0], enable<=wdata[2], out<=0.
  - reg_sel 2: ignores ch. irq &= ~wdata[CHANNELS-1:0] (write-1-to-clear).
- Writes with ch>=CHANNELS are ignored, except reg_sel 2.
- A channel advances only when pulse[i] & enable.
- Mode 0, one-shot:
  - If count>1: count-1.
  - If count==1: count<=0, out<=1, irq<=1, enable<=0.
  - If count==0: no change.
- Mode 1, periodic:
  - If count>1: count-1.
  - If count<=1 and reload!=0: count<=reload, irq<=1, out high for exactly one clk.
  - If reload==0: count held 0, no irq.
- Mode 2, square wave:
  - Reload and expiry as in mode 1, but out toggles on each expiry.
  - irq is set only when out goes 0->1.
- Mode 3, free-run:
  - count+1 per pulse. All-ones wraps to 0 and sets irq.
  - out = count[WIDTH-1], registered.
- rdata by reg_sel:
  - 0: count.
  - 1: zero-extended {irq[ch], out[ch], enable[ch], mode[ch]}.
  - 2: zero-extended irq vector.
  - 3: reload.
  - ch>=CHANNELS with reg_sel≠2 returns 0.
- Simultaneous events:
  - A count/reload write on the same cycle as a pulse on that channel: the write wins and the pulse is discarded.
  - irq set and W1C clear on the same cycle: the set wins.
  - A control write with enable=0 on the same cycle as a pulse: the pulse is discarded.

## Timing
- Reset: count, reload, mode, enable, chan_out, irq and irq_any all 0; tick_q all-ones.
- Reset is asynchronous; asserting it mid-count aborts immediately with no irq.
- Without the sync option: a tick sampled low at edge k-1 and high at edge k updates count/out/irq at edge k. Latency is 0 cycles after the sampling edge.
- Writes take effect at the clk edge where we=1.
- rdata reflects state after that edge, with no read side effects.
- irq_any is combinational from the irq registers.
- Minimum tick high and low time: 1 clk each (2 clk with the sync option).

## Configuration
- TIMER_BANK_SYNC_EN defined: each tick bit passes through a 2-flop synchronizer before edge detect. Use this for ticks from an asynchronous domain. Count latency becomes edge k+2; synchronizer flops reset to all-ones.
- Undefined: tick is assumed synchronous to clk, with edge detect only, as above.

## Test plan
- One-shot, ch0: write reload=3, control=0b100, then 3 tick edges. Required: count 2,1,0; on the third edge irq[0]=1, chan_out[0]=1, control readback enable=0; a 4th edge gives no change.
- Periodic, ch1: reload=2, mode 1 enabled, 6 tick edges. Required: irq[1] set on edges 2, 4 and 6; chan_out[1] high for one clk each time; W1C of 0b010 clears irq[1], irq_any drops.
- Square wave, ch2: reload=1, mode 2, 4 edges. Required: chan_out[2] toggles 1,0,1,0; irq set only on the 1st and 3rd edges.
- Free-run with WIDTH=8: reload=0xFE, mode 3, 2 edges. Required: count 0xFF then 0x00, irq set on the wrap, chan_out follows bit 7.
- Collisions: pulse coincides with a reload write of 5. Required: count reads 5. irq W1C coincides with an expiry: irq stays 1. Write to ch=7 with CHANNELS=3: no state change, rdata 0.
- Reset: rst_n low mid-count with tick held high, then released. Required: all outputs 0 and no count until tick goes low then high; with TIMER_BANK_SYNC_EN, the count lands 2 clk later.
